simon_sequence_gen: RTL and testbench
=====================================

# simon_sequence_gen

Pattern source for the Simon game, sitting directly upstream of the game FSM and driving its `random_num` input. Generates pseudo-random one-hot LED elements from a free-running LFSR, appends one per round to an internal sequence buffer, and replays the stored sequence element by element under a request/advance handshake. The FSM owns round control. This block owns pattern storage, length tracking and replay order.

## Interface
- `MAX_LEN`, 16: sequence buffer depth (elements).
- `SEED`, 8'hA5: LFSR reset value; must be nonzero.
- `clock`  in  1  rising-edge system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `new_game`  in  1  pulse; clears sequence and aborts replay.
- `extend`  in  1  pulse; appends one new random element.
- `replay_start`  in  1  pulse; begins replay from element 0.
- `next`  in  1  advance replay to following element.
- `random_num`  out  8  one-hot current replay element; 8'h00 when not valid.
- `num_valid`  out  1  `random_num` holds a live element.
- `last`  out  1  current element is final element of sequence.
- `seq_len`  out  $clog2(MAX_LEN+1)  number of stored elements.
- `seq_full`  out  1  `seq_len == MAX_LEN`.

## Operation
- LFSR: 8-bit Galois, right shift, tap mask 8'hB8. Every cycle: `lfsr <= (lfsr>>1) ^ (lfsr[0] ? 8'hB8 : 8'h00)`. Runs regardless of state. Never reaches zero.
- Element encoding: `8'b1 << lfsr[2:0]`, using the LFSR value present in the cycle `extend` is sampled (pre-shift value).
- Storage: `mem[0..MAX_LEN-1]` of 8-bit one-hot. Write pointer equals `seq_len`. Read pointer is `rd_ptr`.
- States:
  - IDLE: no replay active.
  - PLAY: replaying. `num_valid=1`. `random_num=mem[rd_ptr]`.
  - DONE: replay finished.
- IDLE or DONE:
  - `extend` with `!seq_full`: `mem[seq_len] <= element`, `seq_len++`. State unchanged.
  - `extend` with `seq_full`: ignored.
  - `replay_start` with `seq_len>0`: `rd_ptr <= 0`, go to PLAY.
  - `replay_start` with `seq_len==0`: ignored.
- PLAY:
  - `next` with `rd_ptr < seq_len-1`: `rd_ptr++`.
  - `next` with `rd_ptr == seq_len-1`: go to DONE, `rd_ptr <= 0`.
  - `extend` and `replay_start` are ignored.
- `new_game`, in any state: `seq_len <= 0`, `rd_ptr <= 0`, go to IDLE. LFSR is not reseeded.
- Priority when inputs coincide: `new_game` > `extend` > `replay_start`. When `extend` and `replay_start` are both asserted in IDLE/DONE, only the append executes.
- `next` outside PLAY is ignored.
- `last` = PLAY && `rd_ptr == seq_len-1`.
- `seq_full` is combinational from `seq_len`.

## Timing
- Reset values: state IDLE, `lfsr=SEED`, `seq_len=0`, `rd_ptr=0`, `random_num=8'h00`, `num_valid=0`, `last=0`, `seq_full=0`. Buffer contents undefined and never exposed.
- Reset is asynchronous assert and synchronous deassert (deassertion is synchronized externally). Reset mid-replay aborts immediately. All outputs go to their reset values in the same cycle.
- `extend` sampled at edge N: `seq_len` updates at N+1. Back-to-back `extend` in consecutive cycles is accepted, one element per cycle.
- `replay_start` sampled at edge N: `num_valid=1` and `random_num=mem[0]` from N+1.
- `next` sampled at edge N in PLAY: the new element, or DONE with `num_valid=0`, is visible from N+1.
- All outputs are registered or derived from registers only. No input-to-output combinational path.

## Test plan
- Reset release, then `extend` on the first two cycles → `seq_len=2`, mem = {8'h20, 8'h04} (LFSR 8'hA5 then 8'hEA). `replay_start` → `random_num=8'h20`, `last=0`. `next` → 8'h04, `last=1`. `next` → `num_valid=0`, `random_num=8'h00`.
- 16 consecutive `extend` → `seq_full=1`, `seq_len=16`. 17th `extend` → `seq_len` stays 16. Replay walks all 16 elements, each exactly one-hot.
- `extend` and `replay_start` asserted together with `seq_len=3` → `seq_len=4`, state remains IDLE, `num_valid=0`.
- `new_game` during PLAY at `rd_ptr=2` → next cycle `seq_len=0`, `num_valid=0`. A following `replay_start` is ignored.
- `reset` asserted low mid-PLAY, asynchronously between edges → outputs go to reset values immediately. After release, `lfsr=8'hA5` and `seq_len=0`.
- `next` and `extend` in PLAY → `extend` ignored (`seq_len` unchanged), `rd_ptr` advances normally.

Source files
------------

// File: rtl/simon_sequence_gen.sv
// Pattern source for the Simon game: free-running Galois LFSR feeding a one-hot
// element buffer that is appended per round and replayed under a next handshake.
module simon_sequence_gen #(
    parameter int          MAX_LEN = 16,
    parameter logic [7:0]  SEED    = 8'hA5,
    localparam int         LW      = $clog2(MAX_LEN + 1),
    localparam int         AW      = $clog2(MAX_LEN)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          new_game,
    input  logic          extend,
    input  logic          replay_start,
    input  logic          next,
    output logic [7:0]    random_num,
    output logic          num_valid,
    output logic          last,
    output logic [LW-1:0] seq_len,
    output logic          seq_full
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [7:0] onehot_enc(input logic [2:0] sel);
        return 8'b0000_0001 << sel;
    endfunction

    state_t        state_r, state_s;
    logic [7:0]    lfsr_r;
    logic [LW-1:0] seq_len_r, seq_len_s;
    logic [LW-1:0] rd_ptr_r, rd_ptr_s;
    logic          wr_en_s;
    logic          full_s;
    logic          last_s;
    logic [7:0]    mem_r [0:MAX_LEN-1];

    assign full_s = (seq_len_r == LW'(MAX_LEN));
    assign last_s = (rd_ptr_r == (seq_len_r - LW'(1)));

    // Control registers: replay state, stored length, replay pointer, LFSR
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            seq_len_r <= '0;
            rd_ptr_r  <= '0;
            lfsr_r    <= SEED;
        end else begin
            state_r   <= state_s;
            seq_len_r <= seq_len_s;
            rd_ptr_r  <= rd_ptr_s;
            lfsr_r    <= lfsr_step(lfsr_r);
        end
    end

    // Element buffer; contents are only ever observed through a PLAY-gated read
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[seq_len_r[AW-1:0]] <= onehot_enc(lfsr_r[2:0]);
        end
    end

    // Next-state logic; new_game outranks extend, which outranks replay_start
    always_comb begin
        state_s   = state_r;
        seq_len_s = seq_len_r;
        rd_ptr_s  = rd_ptr_r;
        wr_en_s   = 1'b0;
        if (new_game) begin
            state_s   = ST_IDLE;
            seq_len_s = '0;
            rd_ptr_s  = '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (extend) begin
                        if (!full_s) begin
                            wr_en_s   = 1'b1;
                            seq_len_s = seq_len_r + LW'(1);
                        end else begin
                            wr_en_s   = 1'b0;
                        end
                    end else if (replay_start) begin
                        if (seq_len_r != '0) begin
                            rd_ptr_s = '0;
                            state_s  = ST_PLAY;
                        end else begin
                            state_s  = state_r;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_PLAY: begin
                    if (next) begin
                        if (last_s) begin
                            state_s  = ST_DONE;
                            rd_ptr_s = '0;
                        end else begin
                            rd_ptr_s = rd_ptr_r + LW'(1);
                        end
                    end else begin
                        rd_ptr_s = rd_ptr_r;
                    end
                end
                default: begin
                    state_s  = ST_IDLE;
                    rd_ptr_s = '0;
                end
            endcase
        end
    end

    // Output decode from registers only; outputs read zero outside PLAY
    always_comb begin
        random_num = 8'h00;
        num_valid  = 1'b0;
        last       = 1'b0;
        if (state_r == ST_PLAY) begin
            random_num = mem_r[rd_ptr_r[AW-1:0]];
            num_valid  = 1'b1;
            last       = last_s;
        end else begin
            random_num = 8'h00;
        end
    end

    assign seq_len  = seq_len_r;
    assign seq_full = full_s;

endmodule

// File: tb/tb_simon_sequence_gen.sv
// Directed table-driven bench for simon_sequence_gen with hand-written sequences
// for buffer fill, coincident pulses, new_game abort and asynchronous reset.
module tb_simon_sequence_gen;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       new_game = 1'b0;
    logic       extend = 1'b0;
    logic       replay_start = 1'b0;
    logic       next = 1'b0;
    logic [7:0] random_num;
    logic       num_valid;
    logic       last;
    logic [4:0] seq_len;
    logic       seq_full;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_lfsr;
    logic [7:0] exp_mem [$];

    typedef struct {
        logic       ng, ext, rs, nx;
        logic [7:0] rn;
        logic       v, l;
        logic [4:0] len;
        logic       full;
    } vec_t;

    vec_t vecs [13];

    simon_sequence_gen #(.MAX_LEN(16), .SEED(8'hA5)) dut (
        .clock(clock), .reset(reset), .new_game(new_game), .extend(extend),
        .replay_start(replay_start), .next(next), .random_num(random_num),
        .num_valid(num_valid), .last(last), .seq_len(seq_len), .seq_full(seq_full)
    );

    always #5 clock = ~clock;

    // Reference LFSR used to predict elements of sequences started mid-run
    always @(posedge clock or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] rn, input logic v,
                           input logic l, input logic [4:0] len, input logic full);
        chk({tag, ".random_num"}, random_num, rn);
        chk({tag, ".num_valid"}, {7'd0, num_valid}, {7'd0, v});
        chk({tag, ".last"}, {7'd0, last}, {7'd0, l});
        chk({tag, ".seq_len"}, {3'd0, seq_len}, {3'd0, len});
        chk({tag, ".seq_full"}, {7'd0, seq_full}, {7'd0, full});
    endtask

    // Called at a negedge: apply pulses for one edge, return at the next negedge
    task automatic drive(input logic ng, input logic ext, input logic rs, input logic nx);
        new_game = ng; extend = ext; replay_start = rs; next = nx;
        @(posedge clock);
        @(negedge clock);
        new_game = 1'b0; extend = 1'b0; replay_start = 1'b0; next = 1'b0;
    endtask

    task automatic push_and_extend(input logic rs);
        exp_mem.push_back(8'b0000_0001 << m_lfsr[2:0]);
        drive(1'b0, 1'b1, rs, 1'b0);
    endtask

    initial begin
        //          ng    ext   rs    nx    rn     v     l     len    full
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 5'd2, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 5'd2, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5'd2, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5'd2, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 5'd2, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 5'd2, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 5'd2, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5'd2, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd3, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0};

        #3;
        chk_all("reset", 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].ng, vecs[i].ext, vecs[i].rs, vecs[i].nx);
            chk_all($sformatf("vec%0d", i), vecs[i].rn, vecs[i].v, vecs[i].l,
                    vecs[i].len, vecs[i].full);
        end

        // Fill to capacity, overflow attempt, then full replay
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        exp_mem.delete();
        for (int i = 0; i < 16; i++) push_and_extend(1'b0);
        chk_all("full16", 8'h00, 1'b0, 1'b0, 5'd16, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("full17", 8'h00, 1'b0, 1'b0, 5'd16, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("walk%0d.elem", i), random_num, exp_mem[i]);
            chk($sformatf("walk%0d.onehot", i), 8'($countones(random_num)), 8'd1);
            chk($sformatf("walk%0d.last", i), {7'd0, last}, {7'd0, (i == 15)});
            drive(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk_all("walk_end", 8'h00, 1'b0, 1'b0, 5'd16, 1'b1);

        // Coincident extend+replay_start, then new_game abort at rd_ptr=2
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        exp_mem.delete();
        for (int i = 0; i < 3; i++) push_and_extend(1'b0);
        push_and_extend(1'b1);
        chk_all("ext_rs", 8'h00, 1'b0, 1'b0, 5'd4, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("play0", exp_mem[0], 1'b1, 1'b0, 5'd4, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("play2", exp_mem[2], 1'b1, 1'b0, 5'd4, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("abort", 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("abort_rs", 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);

        // Asynchronous reset between edges during PLAY
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pre_rst.valid", {7'd0, num_valid}, 8'd1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("post_rst_ext", 8'h00, 1'b0, 1'b0, 5'd1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("post_rst_seed", 8'h20, 1'b1, 1'b1, 5'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
